regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter XLEN, 32, data width of the register file and operands.
REQ-002 Parameter CNT_W, 16, width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  sequencer can accept a command.
REQ-007 cmd_op  input  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 LI, 7 reserved.
REQ-008 cmd_rd / cmd_rs1 / cmd_rs2  input  5 each  destination and source register indices.
REQ-009 cmd_imm  input  XLEN  immediate, used by LI only.
REQ-010 rf_rs1 / rf_rs2  output  5 each  regfile read addresses.
REQ-011 rf_rd1 / rf_rd2  input  XLEN  regfile read data (combinational w.r.t. address).
REQ-012 rf_rd  output  5  regfile write address.
REQ-013 rf_wd  output  XLEN  regfile write data.
REQ-014 rf_w_en  output  1  regfile write enable; the regfile writes on the rising clk edge while high.
REQ-015 rsp_valid  output  1  result available.
REQ-016 rsp_ready  input  1  consumer accepts result.
REQ-017 rsp_data  output  XLEN  result value written (or suppressed) to rd.
REQ-018 rsp_err  output  1  command had reserved opcode.
REQ-019 ops_done  output  CNT_W  count of completed commands, saturating.

Function
REQ-020 FSM states SHALL be IDLE, READ, EXEC, WRITE, RESP.
REQ-021 cmd_ready SHALL be high only in IDLE; a handshake (cmd_valid && cmd_ready) latches op, rd, rs1, rs2, imm and moves to READ.
REQ-022 READ: rf_rs1/rf_rs2 driven from latched indices; next state EXEC.
REQ-023 EXEC: rf_rd1/rf_rd2 sampled, result computed and registered; next state WRITE.
REQ-024 Arithmetic SHALL be XLEN-bit modulo (ADD/SUB wrap, no carry out); SLT yields 1 if rs1 < rs2 signed, else 0; LI yields cmd_imm.
REQ-025 WRITE: rf_w_en high for exactly one cycle with rf_rd = latched rd, rf_wd = result; next state RESP.
REQ-026 rd == 0 SHALL suppress rf_w_en (x0 read-only); response still issued with computed result.
REQ-027 Reserved opcode: rf_w_en suppressed, rsp_err = 1, rsp_data = 0.
REQ-028 RESP: rsp_valid held high with stable rsp_data/rsp_err until rsp_ready; on handshake return to IDLE and increment ops_done (saturate at all-ones).
REQ-029 Latency: handshake at cycle N -> write edge at end of cycle N+3 -> rsp_valid in cycle N+4; one command in flight at most.
REQ-030 rf_w_en SHALL be low in every state except WRITE; rf addresses/data outside READ/WRITE hold last values.
REQ-031 A source equal to the previous command's rd SHALL read the updated value (write completes before next READ).

Reset
REQ-032 rst SHALL asynchronously force state IDLE, rf_w_en 0, rsp_valid 0, rsp_err 0, rsp_data 0, ops_done 0, rf_* addresses 0, rf_wd 0; cmd_ready 1 after release.
REQ-033 Reset during WRITE SHALL deassert rf_w_en immediately; in-flight command discarded, no response, counter not incremented.

Structure
REQ-034 Package regfile_seq_pkg SHALL hold the opcode enum, state enum and XLEN default.
REQ-035 Combinational sub-module seq_alu (op, a, b, imm -> result, err) SHALL implement REQ-024/027.

Verification (bench includes a behavioural regfile)
REQ-036 LI x1=10, LI x2=20, ADD x3=x1+x2 -> rsp_data 30, regfile x3 = 30.
REQ-037 LI x1=10, LI x2=5, SUB x3 -> 5; SUB x4=x2-x1 -> 0xFFFFFFFB.
REQ-038 LI x1=0xFFFFFFFF, LI x2=1, SLT x5=x1,x2 -> 1; swapped sources -> 0.
REQ-039 ADD rd=x0 -> rf_w_en never high, rsp_valid with result, x0 stays 0; op 7 -> rsp_err 1.
REQ-040 rsp_ready low 5 cycles -> rsp_valid/rsp_data stable, cmd_ready 0, ops_done unchanged until accept.
REQ-041 rst asserted in WRITE -> rf_w_en 0 same cycle, target register unchanged, ops_done 0, cmd_ready 1 after release.

Source files
------------

// File: rtl/regfile_seq_pkg.sv
// Shared types for the register-file sequencer: opcode and FSM state encodings.
package regfile_seq_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_LI  = 3'd6,
        OP_RSV = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_sequencer_alu.sv
// Combinational ALU for the sequencer; modulo-XLEN arithmetic, reserved opcode flags err with zero result.
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [XLEN-1:0] i_imm,
    output logic [XLEN-1:0] o_result,
    output logic            o_err
);

    always_comb begin
        o_result = '0;
        o_err    = 1'b0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLT:  o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_LI:   o_result = i_imm;
            default: o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// One-command-at-a-time sequencer: IDLE -> READ -> EXEC -> WRITE -> RESP around an external regfile.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [4:0]       cmd_rd,
    input  logic [4:0]       cmd_rs1,
    input  logic [4:0]       cmd_rs2,
    input  logic [XLEN-1:0]  cmd_imm,
    output logic [4:0]       rf_rs1,
    output logic [4:0]       rf_rs2,
    input  logic [XLEN-1:0]  rf_rd1,
    input  logic [XLEN-1:0]  rf_rd2,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wd,
    output logic             rf_w_en,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic             rsp_err,
    output logic [CNT_W-1:0] ops_done
);

    state_e            r_state;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_imm;
    logic              r_err;
    logic [XLEN-1:0]   w_result;
    logic              w_err;

    seq_alu #(.XLEN(XLEN)) u_alu (
        .i_op     (r_op),
        .i_a      (rf_rd1),
        .i_b      (rf_rd2),
        .i_imm    (r_imm),
        .o_result (w_result),
        .o_err    (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_rd      <= '0;
            r_imm     <= '0;
            r_err     <= 1'b0;
            cmd_ready <= 1'b1;
            rf_rs1    <= '0;
            rf_rs2    <= '0;
            rf_rd     <= '0;
            rf_wd     <= '0;
            rf_w_en   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op      <= cmd_op;
                        r_rd      <= cmd_rd;
                        r_imm     <= cmd_imm;
                        rf_rs1    <= cmd_rs1;
                        rf_rs2    <= cmd_rs2;
                        cmd_ready <= 1'b0;
                        r_state   <= S_READ;
                    end
                end
                S_READ: r_state <= S_EXEC;
                S_EXEC: begin
                    rf_rd   <= r_rd;
                    rf_wd   <= w_result;
                    r_err   <= w_err;
                    // x0 is hardwired zero and reserved ops never commit
                    rf_w_en <= !w_err && (r_rd != 5'd0);
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    rf_w_en   <= 1'b0;
                    rsp_valid <= 1'b1;
                    rsp_data  <= rf_wd;
                    rsp_err   <= r_err;
                    r_state   <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (ops_done != '1)
                            ops_done <= ops_done + {{(CNT_W-1){1'b0}}, 1'b1};
                        cmd_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    rf_w_en   <= 1'b0;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench with behavioural regfile, shadow register model and response scoreboard.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [4:0]  cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
    logic [31:0] cmd_imm = '0;
    logic [4:0]  rf_rs1, rf_rs2, rf_rd;
    logic [31:0] rf_rd1, rf_rd2, rf_wd;
    logic        rf_w_en;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [15:0] ops_done;

    logic [31:0] bench_rf [32];
    logic [31:0] shadow   [32];
    logic [32:0] exp_q [$];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          exp_ops = 0;

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) begin
            bench_rf[i] = '0;
            shadow[i]   = '0;
        end
    end

    always @(posedge clk)
        if (rf_w_en && rf_rd != 5'd0) bench_rf[rf_rd] <= rf_wd;

    assign rf_rd1 = bench_rf[rf_rs1];
    assign rf_rd2 = bench_rf[rf_rs2];

    regfile_sequencer #(.XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_w_en(rf_w_en),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .ops_done(ops_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm);
        int w = 0;
        while (!cmd_ready && w < 20) begin
            tick();
            w++;
        end
        chk("cmd_ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input int hold);
        logic [31:0] a, b, r;
        logic        e, we_exp;
        logic [32:0] ent;
        int          lat, we;
        logic [15:0] ops_before;
        drive_cmd(op, rd, rs1, rs2, imm);
        a = shadow[rs1]; b = shadow[rs2]; e = 1'b0;
        case (op)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd6: r = imm;
            default: begin r = '0; e = 1'b1; end
        endcase
        we_exp = !e && rd != 5'd0;
        if (we_exp) shadow[rd] = r;
        exp_q.push_back({e, r});
        lat = 0; we = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
            if (rf_w_en) we++;
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_wen_cycles"}, we, we_exp ? 1 : 0);
        ops_before = ops_done;
        chk({tag, "_ops_before"}, {16'd0, ops_before}, exp_ops);
        ent = exp_q[0];
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
            chk({tag, "_hold_data"}, rsp_data, ent[31:0]);
            chk({tag, "_hold_cmd_ready"}, {31'd0, cmd_ready}, 32'd0);
            chk({tag, "_hold_ops"}, {16'd0, ops_done}, {16'd0, ops_before});
        end
        ent = exp_q.pop_front();
        chk({tag, "_data"}, rsp_data, ent[31:0]);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, ent[32]});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        exp_ops++;
        chk({tag, "_ops_after"}, {16'd0, ops_done}, exp_ops);
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rf_x0"}, bench_rf[0], 32'd0);
        if (rd != 5'd0) chk({tag, "_rf_rd"}, bench_rf[rd], shadow[rd]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        #12;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_w_en", {31'd0, rf_w_en}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_ops", {16'd0, ops_done}, 32'd0);
        chk("rst_addr", {17'd0, rf_rs1, rf_rs2, rf_rd}, 32'd0);
        chk("rst_wd", rf_wd, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        do_cmd("li_x1", 3'd6, 5'd1, 5'd0, 5'd0, 32'd10, 0);
        do_cmd("li_x2", 3'd6, 5'd2, 5'd0, 5'd0, 32'd20, 0);
        do_cmd("add_x3", 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        chk("add_x3_val", bench_rf[3], 32'd30);

        do_cmd("li_x1b", 3'd6, 5'd1, 5'd0, 5'd0, 32'd10, 0);
        do_cmd("li_x2b", 3'd6, 5'd2, 5'd0, 5'd0, 32'd5, 0);
        do_cmd("sub_x3", 3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 0);
        do_cmd("sub_x4", 3'd1, 5'd4, 5'd2, 5'd1, 32'd0, 0);
        chk("sub_x4_val", bench_rf[4], 32'hFFFF_FFFB);

        do_cmd("li_x1c", 3'd6, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 0);
        do_cmd("li_x2c", 3'd6, 5'd2, 5'd0, 5'd0, 32'd1, 0);
        do_cmd("slt_a", 3'd5, 5'd5, 5'd1, 5'd2, 32'd0, 0);
        chk("slt_a_val", bench_rf[5], 32'd1);
        do_cmd("slt_b", 3'd5, 5'd5, 5'd2, 5'd1, 32'd0, 0);
        chk("slt_b_val", bench_rf[5], 32'd0);

        do_cmd("add_x0", 3'd0, 5'd0, 5'd2, 5'd2, 32'd0, 0);
        do_cmd("rsv", 3'd7, 5'd3, 5'd1, 5'd2, 32'h1234_5678, 0);
        chk("rsv_x3_kept", bench_rf[3], 32'd5);

        do_cmd("and_hold", 3'd2, 5'd6, 5'd1, 5'd3, 32'd0, 5);
        do_cmd("or", 3'd3, 5'd7, 5'd3, 5'd4, 32'd0, 0);
        do_cmd("xor", 3'd4, 5'd8, 5'd1, 5'd3, 32'd0, 2);

        // abort a command while its write is pending
        drive_cmd(3'd6, 5'd6, 5'd0, 5'd0, 32'hAAAA_AAAA);
        w = 0;
        while (!rf_w_en && w < 10) begin
            tick();
            w++;
        end
        chk("abort_reach_write", {31'd0, rf_w_en}, 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_w_en", {31'd0, rf_w_en}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        exp_ops = 0;
        tick();
        chk("abort_x6_kept", bench_rf[6], shadow[6]);
        chk("abort_ops", {16'd0, ops_done}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_q_empty", exp_q.size(), 0);

        do_cmd("post_abort_add", 3'd0, 5'd9, 5'd6, 5'd6, 32'd0, 0);
        chk("post_abort_val", bench_rf[9], 32'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
